// File: rtl/duty_pkg.sv
// Shared widths, repeat-FSM state type and the level-to-duty expansion
// for the duty level selector.
package duty_pkg;

  localparam int LEVEL_W = 4;
  localparam int DUTY_W  = 8;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;

  // Per-button auto-repeat states (only instantiated with AUTOREPEAT_EN)
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  // Full-scale expansion: {level, level} == level * 17, so the 8->4
  // reduction in the LED path recovers the same level.
  function automatic logic [DUTY_W-1:0] level_to_duty(input logic [LEVEL_W-1:0] lvl);
    return {lvl, lvl};
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One pushbutton: 2-flop synchroniser, counter debouncer, one-cycle press
// pulse and, when AUTOREPEAT_EN is defined, a hold/auto-repeat FSM.
// o_event is the step request seen by the level logic.
module button_debounce
  import duty_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
`ifdef AUTOREPEAT_EN
  input  logic i_other_held,
  output logic o_held,
`endif
  output logic o_event
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Reject configurations the counters cannot represent
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_RATE < 1) begin : g_bad_params
    $error("button_debounce: parameter out of range");
  end

  logic            r_sync1;
  logic            r_sync2;
  logic            r_state;
  logic            r_press;
  logic [DB_W-1:0] r_db_cnt;

  // Two-flop synchroniser for the asynchronous raw button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  // Debouncer: flip once the difference persists DEBOUNCE_CYCLES cycles;
  // pulse r_press in the same edge as a 0->1 flip
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= 1'b0;
      r_press  <= 1'b0;
      r_db_cnt <= '0;
    end else if (r_sync2 != r_state) begin
      if (r_db_cnt == DB_LAST) begin
        r_state  <= r_sync2;
        r_press  <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_press  <= 1'b0;
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end else begin
      r_press  <= 1'b0;
      r_db_cnt <= '0;
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

  rpt_state_t       r_rpt_state;
  logic [RPT_W-1:0] r_rpt_cnt;
  logic             r_step;

  // Repeat FSM; r_rpt_cnt tracks cycles since the press pulse so the first
  // repeat lands REPEAT_DELAY cycles after it, then every REPEAT_RATE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rpt_state <= IDLE;
      r_rpt_cnt   <= '0;
      r_step      <= 1'b0;
    end else begin
      r_step <= 1'b0;
      if (!r_state || i_other_held) begin
        r_rpt_state <= IDLE;
        r_rpt_cnt   <= '0;
      end else begin
        case (r_rpt_state)
          IDLE: begin
            if (r_press) begin
              r_rpt_state <= HOLD;
              r_rpt_cnt   <= RPT_W'(1);
            end
          end
          HOLD: begin
            if (r_rpt_cnt == DELAY_LAST) begin
              r_rpt_state <= REPEAT;
              r_rpt_cnt   <= '0;
              r_step      <= 1'b1;
            end else begin
              r_rpt_cnt <= r_rpt_cnt + 1'b1;
            end
          end
          REPEAT: begin
            if (r_rpt_cnt == RATE_LAST) begin
              r_rpt_cnt <= '0;
              r_step    <= 1'b1;
            end else begin
              r_rpt_cnt <= r_rpt_cnt + 1'b1;
            end
          end
          default: begin
            r_rpt_state <= IDLE;
            r_rpt_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign o_held  = r_state;
  assign o_event = r_press | r_step;
`else
  assign o_event = r_press;
`endif

endmodule

// File: rtl/duty_level_selector.sv
// Pushbutton-driven 4-bit level with saturation, expanded to an 8-bit
// duty word. Optional auto-repeat on held buttons: define AUTOREPEAT_EN.
module duty_level_selector
  import duty_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RESET_LEVEL     = 0,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_up,
  input  logic               btn_down,
  output logic [LEVEL_W-1:0] level,
  output logic [DUTY_W-1:0]  duty,
  output logic               changed
);

  localparam logic [LEVEL_W-1:0] RST_LVL = LEVEL_W'(RESET_LEVEL);

  logic               w_up_evt;
  logic               w_down_evt;
  logic [LEVEL_W-1:0] w_level_next;
  logic               w_changed_next;
  logic [LEVEL_W-1:0] r_level;
  logic [DUTY_W-1:0]  r_duty;
  logic               r_changed;

`ifdef AUTOREPEAT_EN
  logic w_up_held;
  logic w_down_held;
`endif

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE)
  ) u_up (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_btn       (btn_up),
`ifdef AUTOREPEAT_EN
    .i_other_held(w_down_held),
    .o_held      (w_up_held),
`endif
    .o_event     (w_up_evt)
  );

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE)
  ) u_down (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_btn       (btn_down),
`ifdef AUTOREPEAT_EN
    .i_other_held(w_up_held),
    .o_held      (w_down_held),
`endif
    .o_event     (w_down_evt)
  );

  // Saturating step; simultaneous up and down cancel
  always_comb begin
    w_level_next   = r_level;
    w_changed_next = 1'b0;
    if (w_up_evt && !w_down_evt && (r_level != LEVEL_MAX)) begin
      w_level_next   = r_level + 1'b1;
      w_changed_next = 1'b1;
    end else if (w_down_evt && !w_up_evt && (r_level != '0)) begin
      w_level_next   = r_level - 1'b1;
      w_changed_next = 1'b1;
    end
  end

  // Level, duty and change pulse all load from the same next value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level   <= RST_LVL;
      r_duty    <= level_to_duty(RST_LVL);
      r_changed <= 1'b0;
    end else begin
      r_level   <= w_level_next;
      r_duty    <= level_to_duty(w_level_next);
      r_changed <= w_changed_next;
    end
  end

  assign level   = r_level;
  assign duty    = r_duty;
  assign changed = r_changed;

endmodule

// File: tb/tb_duty_level_selector.sv
// Bench for duty_level_selector: directed scenarios plus randomized presses
// checked against a plain saturating-counter reference model.
module tb_duty_level_selector;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 8;
  localparam int RL = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [3:0] level;
  logic [7:0] duty;
  logic       changed;

  int n_checks = 0;
  int n_pass = 0;
  int pulse_cnt = 0;
  int model_level = RL;

  duty_level_selector #(
    .DEBOUNCE_CYCLES(DB),
    .RESET_LEVEL    (RL),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_up  (btn_up),
    .btn_down(btn_down),
    .level   (level),
    .duty    (duty),
    .changed (changed)
  );

  always #5 clk = ~clk;

  // Count every cycle in which changed is observed high
  always @(negedge clk) begin
    if (changed === 1'b1) pulse_cnt++;
  end

  // Reference: one accepted press moves the level by one, clamped to 0..15
  function automatic int ref_step(input int lvl, input bit up, input bit dn);
    if (up && !dn) return (lvl < 15) ? lvl + 1 : lvl;
    if (dn && !up) return (lvl > 0) ? lvl - 1 : lvl;
    return lvl;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    btn_up = 1'b0;
    btn_down = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_level = RL;
    repeat (2) @(negedge clk);
  endtask

  // Hold the given buttons for 'hold' cycles, release, let the release settle
  task automatic do_press(input bit up, input bit dn, input int hold);
    @(negedge clk);
    btn_up = up;
    btn_down = dn;
    repeat (hold) @(negedge clk);
    btn_up = 1'b0;
    btn_down = 1'b0;
    repeat (10) @(negedge clk);
    model_level = ref_step(model_level, up, dn);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (level !== 4'(RL)) $display("FAIL reset_level: got %0d want %0d", level, RL);
    else n_pass++;
    n_checks++;
    if (duty !== 8'(RL * 17)) $display("FAIL reset_duty: got %0h want %0h", duty, RL * 17);
    else n_pass++;
    n_checks++;
    if (changed !== 1'b0) $display("FAIL reset_changed: got %b want 0", changed);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_level = RL;
    repeat (2) @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_single_press();
    int p0;
    int lat;
    apply_reset();
    p0 = pulse_cnt;
    lat = -1;
    @(negedge clk);
    btn_up = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k == 10) btn_up = 1'b0;
      if (changed === 1'b1 && lat < 0) lat = k;
    end
    n_checks++;
    if (lat != 7) $display("FAIL press_latency: got %0d want 7", lat);
    else n_pass++;
    n_checks++;
    if (pulse_cnt - p0 != 1) $display("FAIL press_pulses: got %0d want 1", pulse_cnt - p0);
    else n_pass++;
    n_checks++;
    if (level !== 4'd1) $display("FAIL press_level: got %0d want 1", level);
    else n_pass++;
    n_checks++;
    if (duty !== 8'h11) $display("FAIL press_duty: got %0h want 11", duty);
    else n_pass++;
    model_level = 1;
    $display("test_single_press latency=%0d level=%0d", lat, level);
  endtask

  task automatic test_bounce();
    int p0;
    bit pat[7] = '{1, 1, 1, 0, 1, 1, 0};
    apply_reset();
    p0 = pulse_cnt;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      btn_up = pat[i];
    end
    repeat (15) @(negedge clk);
    n_checks++;
    if (level !== 4'd0) $display("FAIL bounce_level: got %0d want 0", level);
    else n_pass++;
    n_checks++;
    if (pulse_cnt != p0) $display("FAIL bounce_pulses: got %0d want 0", pulse_cnt - p0);
    else n_pass++;
    $display("test_bounce level=%0d", level);
  endtask

  task automatic test_saturation();
    int p0;
    int exp_lvl;
    apply_reset();
    for (int i = 1; i <= 16; i++) begin
      p0 = pulse_cnt;
      exp_lvl = ref_step(model_level, 1'b1, 1'b0);
      do_press(1'b1, 1'b0, 8);
      n_checks++;
      if (level !== 4'(exp_lvl)) $display("FAIL sat_up_level[%0d]: got %0d want %0d", i, level, exp_lvl);
      else n_pass++;
      n_checks++;
      if (duty !== 8'(exp_lvl * 17)) $display("FAIL sat_up_duty[%0d]: got %0h want %0h", i, duty, exp_lvl * 17);
      else n_pass++;
      n_checks++;
      if (pulse_cnt - p0 != ((i <= 15) ? 1 : 0))
        $display("FAIL sat_up_pulses[%0d]: got %0d want %0d", i, pulse_cnt - p0, (i <= 15) ? 1 : 0);
      else n_pass++;
      $display("sat up press %0d level=%0d", i, level);
    end
    apply_reset();
    p0 = pulse_cnt;
    do_press(1'b0, 1'b1, 8);
    n_checks++;
    if (level !== 4'd0) $display("FAIL sat_down_level: got %0d want 0", level);
    else n_pass++;
    n_checks++;
    if (pulse_cnt != p0) $display("FAIL sat_down_pulses: got %0d want 0", pulse_cnt - p0);
    else n_pass++;
    $display("sat down press level=%0d", level);
  endtask

  task automatic test_both();
    int p0;
    apply_reset();
    for (int i = 0; i < 5; i++) do_press(1'b1, 1'b0, 8);
    p0 = pulse_cnt;
    do_press(1'b1, 1'b1, 10);
    n_checks++;
    if (level !== 4'd5) $display("FAIL both_level: got %0d want 5", level);
    else n_pass++;
    n_checks++;
    if (pulse_cnt != p0) $display("FAIL both_pulses: got %0d want 0", pulse_cnt - p0);
    else n_pass++;
    $display("test_both level=%0d", level);
  endtask

  task automatic test_random();
    int p0;
    int prev;
    int sel;
    bit up;
    bit dn;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 4));
      up = (sel == 0 || sel == 1 || sel == 4);
      dn = (sel == 2 || sel == 3 || sel == 4);
      prev = model_level;
      p0 = pulse_cnt;
      do_press(up, dn, int'($urandom_range(8, 15)));
      n_checks++;
      if (level !== 4'(model_level)) $display("FAIL rand_level[%0d]: got %0d want %0d", i, level, model_level);
      else n_pass++;
      n_checks++;
      if (duty !== 8'(model_level * 17)) $display("FAIL rand_duty[%0d]: got %0h want %0h", i, duty, model_level * 17);
      else n_pass++;
      n_checks++;
      if (pulse_cnt - p0 != ((prev != model_level) ? 1 : 0))
        $display("FAIL rand_pulses[%0d]: got %0d want %0d", i, pulse_cnt - p0, (prev != model_level) ? 1 : 0);
      else n_pass++;
      $display("rand press %0d up=%0b dn=%0b level=%0d", i, up, dn, level);
    end
  endtask

  task automatic test_autorepeat();
    int p0;
    int exp_lvl;
    bit seen;
    apply_reset();
    p0 = pulse_cnt;
    seen = 1'b0;
    @(negedge clk);
    btn_up = 1'b1;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (changed === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) $display("FAIL repeat_first_step: got none want pulse within 30 cycles");
    else n_pass++;
    repeat (48) @(negedge clk);
    btn_up = 1'b0;
    repeat (30) @(negedge clk);
`ifdef AUTOREPEAT_EN
    exp_lvl = 6;
`else
    exp_lvl = 1;
`endif
    n_checks++;
    if (level !== 4'(exp_lvl)) $display("FAIL repeat_level: got %0d want %0d", level, exp_lvl);
    else n_pass++;
    n_checks++;
    if (pulse_cnt - p0 != exp_lvl) $display("FAIL repeat_pulses: got %0d want %0d", pulse_cnt - p0, exp_lvl);
    else n_pass++;
    model_level = exp_lvl;
    $display("test_autorepeat level=%0d", level);
  endtask

  task automatic test_reset_mid_hold();
    int p0;
    apply_reset();
    for (int i = 0; i < 7; i++) do_press(1'b1, 1'b0, 8);
    @(negedge clk);
    btn_up = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (level !== 4'd7) $display("FAIL midhold_pre_level: got %0d want 7", level);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (level !== 4'(RL) || duty !== 8'(RL * 17) || changed !== 1'b0)
      $display("FAIL midhold_reset: got level=%0d duty=%0h changed=%b want %0d/%0h/0", level, duty, changed, RL, RL * 17);
    else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    p0 = pulse_cnt;
    repeat (14) @(negedge clk);
    btn_up = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++;
    if (level !== 4'd1) $display("FAIL midhold_level: got %0d want 1", level);
    else n_pass++;
    n_checks++;
    if (pulse_cnt - p0 != 1) $display("FAIL midhold_pulses: got %0d want 1", pulse_cnt - p0);
    else n_pass++;
    model_level = 1;
    $display("test_reset_mid_hold level=%0d", level);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_saturation();
    test_both();
    test_random();
    test_autorepeat();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
